sram_ctrl: RTL and testbench

Request-side controller sitting directly upstream of the 4-word × 4-bit `SRAM` macro. It accepts single read or write requests over a valid/ready handshake. It sequences the SRAM's `CS`/`WE`/`RD`/`Addr`/`dataIn` pins with registered outputs, captures `Q` after the configured read latency, and returns read data as a one-cycle response pulse. It is the only agent that drives the SRAM pins.

---
 rtl/sram_ctrl_pkg.sv | 27 ++
 rtl/sram_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the sram_ctrl request-side SRAM controller.
package sram_ctrl_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_e;

    // Flat state codes used by the FSM register; kept in step with state_e.
    localparam logic [1:0] ST_INIT  = INIT;
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WRITE = WRITE;
    localparam logic [1:0] ST_READ  = READ;

    localparam logic RST_CS        = 1'b0;
    localparam logic RST_WE        = 1'b0;
    localparam logic RST_RD        = 1'b0;
    localparam logic RST_RSP_VALID = 1'b0;
    localparam logic RST_INIT_DONE = 1'b0;

endpackage

// File: rtl/sram_ctrl.sv
// Single-request SRAM controller with registered CS/WE/RD/Addr/dataIn pins.
// Define SRAM_CTRL_INIT_EN to zero-fill the macro after every reset.
import sram_ctrl_pkg::*;

module sram_ctrl #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic              CS,
    output logic              WE,
    output logic              RD,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] dataIn,
    input  logic [DATA_W-1:0] Q
);

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

`ifdef SRAM_CTRL_INIT_EN
    localparam logic [1:0] ST_RESET = ST_INIT;
    localparam logic [ADDR_W:0] INIT_END = {1'b1, {ADDR_W{1'b0}}};
    logic [ADDR_W:0] init_cnt;
`else
    localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

    logic [1:0] state;
    logic [2:0] lat_cnt;

    assign req_ready = (state == ST_IDLE) && !Rst;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_RESET;
            CS        <= RST_CS;
            WE        <= RST_WE;
            RD        <= RST_RD;
            Addr      <= '0;
            dataIn    <= '0;
            rsp_valid <= RST_RSP_VALID;
            rsp_rdata <= '0;
            lat_cnt   <= '0;
            init_done <= RST_INIT_DONE;
`ifdef SRAM_CTRL_INIT_EN
            init_cnt  <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifndef SRAM_CTRL_INIT_EN
            init_done <= 1'b1;
`endif
            case (state)
`ifdef SRAM_CTRL_INIT_EN
                ST_INIT: begin
                    // One zero-write per cycle; the terminal count leaves INIT.
                    if (init_cnt == INIT_END) begin
                        state     <= ST_IDLE;
                        CS        <= 1'b0;
                        WE        <= 1'b0;
                        RD        <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        CS       <= 1'b1;
                        WE       <= 1'b1;
                        RD       <= 1'b0;
                        Addr     <= init_cnt[ADDR_W-1:0];
                        dataIn   <= '0;
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
`endif
                ST_IDLE: begin
                    CS <= 1'b0;
                    WE <= 1'b0;
                    RD <= 1'b0;
                    if (req_valid) begin
                        CS   <= 1'b1;
                        Addr <= req_addr;
                        if (req_we) begin
                            state  <= ST_WRITE;
                            WE     <= 1'b1;
                            dataIn <= req_wdata;
                        end else begin
                            state   <= ST_READ;
                            RD      <= 1'b1;
                            lat_cnt <= LAT_LOAD;
                        end
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                    CS    <= 1'b0;
                    WE    <= 1'b0;
                end
                ST_READ: begin
                    // Q is sampled on the edge that ends the RD_LAT-th RD cycle.
                    if (lat_cnt == 3'd0) begin
                        state     <= ST_IDLE;
                        CS        <= 1'b0;
                        RD        <= 1'b0;
                        rsp_rdata <= Q;
                        rsp_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    CS    <= 1'b0;
                    WE    <= 1'b0;
                    RD    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl driving a behavioural 4x4 SRAM; honours SRAM_CTRL_INIT_EN.
module tb_sram_ctrl;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 2;
    localparam int RD_LAT = 3;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              init_done;
    logic              CS, WE, RD;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] Q;

    int vectors = 0;
    int miscompares = 0;
    int rsp_seen = 0;
    int exp_rsp = 0;
    logic [DATA_W-1:0] ref_mem [4];

    sram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_dut (
        .Clk(Clk), .Rst(Rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .CS(CS), .WE(WE), .RD(RD), .Addr(Addr), .dataIn(dataIn), .Q(Q)
    );

    always #5 Clk = ~Clk;

    // Behavioural SRAM: synchronous write, asynchronous read; preloaded with 5s.
    logic [DATA_W-1:0] sram_mem [4];
    bit filled = 1'b0;
    always @(posedge Clk) begin
        if (!filled) begin
            for (int i = 0; i < 4; i++) sram_mem[i] <= 4'h5;
            filled <= 1'b1;
        end else if (CS && WE) begin
            sram_mem[Addr] <= dataIn;
        end
    end
    assign Q = sram_mem[Addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (rsp_valid) rsp_seen++;
        if (filled) begin
            chk("we_and_rd_exclusive", {31'd0, WE & RD}, 32'd0);
            chk("cs_is_we_or_rd", {31'd0, CS}, {31'd0, WE | RD});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input logic we, input logic [1:0] addr,
                          input logic [3:0] wdata, input logic [3:0] exp);
        int n = 0;
        while (!req_ready && n < 64) begin
            @(negedge Clk);
            n++;
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        chk("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
        chk("rsp_single_pulse", {31'd0, rsp_valid}, 32'd0);
        if (we) begin
            chk("wr_we", {31'd0, WE}, 32'd1);
            chk("wr_rd", {31'd0, RD}, 32'd0);
            chk("wr_addr", {30'd0, Addr}, {30'd0, addr});
            chk("wr_data", {28'd0, dataIn}, {28'd0, wdata});
            ref_mem[addr] = wdata;
            @(negedge Clk);
            chk("wr_ready_back", {31'd0, req_ready}, 32'd1);
            chk("wr_we_drop", {31'd0, WE}, 32'd0);
        end else begin
            for (int k = 0; k < RD_LAT; k++) begin
                chk("rd_rd", {31'd0, RD}, 32'd1);
                chk("rd_we", {31'd0, WE}, 32'd0);
                chk("rd_addr", {30'd0, Addr}, {30'd0, addr});
                chk("rd_early_rsp", {31'd0, rsp_valid}, 32'd0);
                chk("rd_ready_low", {31'd0, req_ready}, 32'd0);
                @(negedge Clk);
            end
            chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rd_data", {28'd0, rsp_rdata}, {28'd0, exp});
            chk("rd_ready_back", {31'd0, req_ready}, 32'd1);
            chk("rd_pin_drop", {31'd0, RD}, 32'd0);
            exp_rsp++;
        end
    endtask

    // Post-release bring-up: either the zero-fill walk or immediate readiness.
    task automatic after_release();
`ifdef SRAM_CTRL_INIT_EN
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            chk("init_done_low", {31'd0, init_done}, 32'd0);
            chk("init_ready_low", {31'd0, req_ready}, 32'd0);
            chk("init_we", {31'd0, WE}, 32'd1);
            chk("init_addr", {30'd0, Addr}, 32'(k - 1));
            chk("init_data", {28'd0, dataIn}, 32'd0);
        end
        @(negedge Clk);
        chk("init_done_rise", {31'd0, init_done}, 32'd1);
        chk("init_ready_rise", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) ref_mem[i] = 4'h0;
`else
        @(negedge Clk);
        chk("init_done_noinit", {31'd0, init_done}, 32'd1);
        chk("ready_noinit", {31'd0, req_ready}, 32'd1);
`endif
    endtask

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b1, 2'd0, 4'b1111, 4'h0};
        tbl[1] = '{1'b1, 2'd1, 4'b0001, 4'h0};
        tbl[2] = '{1'b1, 2'd2, 4'b1100, 4'h0};
        tbl[3] = '{1'b1, 2'd3, 4'b1010, 4'h0};
        tbl[4] = '{1'b0, 2'd0, 4'h0, 4'b1111};
        tbl[5] = '{1'b0, 2'd1, 4'h0, 4'b0001};
        tbl[6] = '{1'b0, 2'd2, 4'h0, 4'b1100};
        tbl[7] = '{1'b0, 2'd3, 4'h0, 4'b1010};

        Rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 4'h5;
        repeat (2) @(negedge Clk);
        chk("rst_cs", {31'd0, CS}, 32'd0);
        chk("rst_we", {31'd0, WE}, 32'd0);
        chk("rst_rd", {31'd0, RD}, 32'd0);
        chk("rst_addr", {30'd0, Addr}, 32'd0);
        chk("rst_datain", {28'd0, dataIn}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {28'd0, rsp_rdata}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        Rst = 1'b0;
        after_release();

`ifdef SRAM_CTRL_INIT_EN
        for (int a = 0; a < 4; a++) do_req(1'b0, 2'(a), 4'h0, 4'h0);
`endif

        for (int i = 0; i < 8; i++) do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

        // Read @2 with a write presented while the read is still in flight.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd2; req_wdata = 4'h0;
        @(posedge Clk);
        @(negedge Clk);
        req_we = 1'b1; req_addr = 2'd1; req_wdata = 4'b0111;
        for (int k = 0; k < RD_LAT; k++) begin
            chk("blk_rd", {31'd0, RD}, 32'd1);
            chk("blk_we_held_off", {31'd0, WE}, 32'd0);
            chk("blk_ready_low", {31'd0, req_ready}, 32'd0);
            @(negedge Clk);
        end
        chk("blk_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("blk_rsp_data", {28'd0, rsp_rdata}, {28'd0, ref_mem[2]});
        chk("blk_ready_back", {31'd0, req_ready}, 32'd1);
        exp_rsp++;
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        chk("blk_wr_we", {31'd0, WE}, 32'd1);
        chk("blk_wr_addr", {30'd0, Addr}, 32'd1);
        chk("blk_wr_data", {28'd0, dataIn}, 32'b0111);
        chk("blk_no_second_rsp", {31'd0, rsp_valid}, 32'd0);
        ref_mem[1] = 4'b0111;
        @(negedge Clk);
        do_req(1'b0, 2'd1, 4'h0, ref_mem[1]);

        // Reset in the middle of a read: response is dropped, pins clear.
        @(negedge Clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd3;
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        chk("abort_rd_started", {31'd0, RD}, 32'd1);
        Rst = 1'b1;
        @(negedge Clk);
        chk("abort_cs", {31'd0, CS}, 32'd0);
        chk("abort_rd", {31'd0, RD}, 32'd0);
        chk("abort_addr", {30'd0, Addr}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        Rst = 1'b0;
        after_release();
        repeat (RD_LAT + 1) @(negedge Clk);
        #1;
        chk("abort_no_response", 32'(rsp_seen), 32'(exp_rsp));
        for (int a = 0; a < 4; a++) do_req(1'b0, 2'(a), 4'h0, ref_mem[a]);

        // Random legal traffic against the array model.
        for (int i = 0; i < 200; i++) begin
            logic       rwe;
            logic [1:0] raddr;
            logic [3:0] rdat;
            rwe   = 1'($urandom_range(0, 1));
            raddr = 2'($urandom_range(0, 3));
            rdat  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) @(negedge Clk);
            do_req(rwe, raddr, rdat, ref_mem[raddr]);
        end

        repeat (3) @(negedge Clk);
        #1;
        chk("rsp_pulse_count", 32'(rsp_seen), 32'(exp_rsp));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
